// File: rtl/light_sequencer.sv
// Traffic-light sequencer: green -> yellow -> red -> walk -> clear -> green.
// Phases are timed by a millisecond prescaler. Pedestrian presses are latched
// until the walk phase that serves them.
module light_sequencer #(
    parameter int C_CLK_FRQ   = 100000000,
    parameter int C_GREEN_MS  = 5000,
    parameter int C_YELLOW_MS = 2000,
    parameter int C_RED_MS    = 1000,
    parameter int C_WALK_MS   = 4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] inPedestrian,
    output logic [1:0] outLight,
    output logic       outReqPending
);

    localparam int K      = C_CLK_FRQ / 1000;
    localparam int MAX_GY = (C_GREEN_MS > C_YELLOW_MS) ? C_GREEN_MS : C_YELLOW_MS;
    localparam int MAX_RW = (C_RED_MS > C_WALK_MS) ? C_RED_MS : C_WALK_MS;
    localparam int MAX_MS = (MAX_GY > MAX_RW) ? MAX_GY : MAX_RW;
    localparam int PW     = (K > 1) ? $clog2(K) : 1;
    // One extra count of headroom: green steps to C_GREEN_MS on expiry, then freezes.
    localparam int MW     = $clog2(MAX_MS + 1);

    localparam logic [PW-1:0] PRESC_LAST  = PW'(K - 1);
    localparam logic [MW-1:0] GREEN_LAST  = MW'(C_GREEN_MS - 1);
    localparam logic [MW-1:0] YELLOW_LAST = MW'(C_YELLOW_MS - 1);
    localparam logic [MW-1:0] RED_LAST    = MW'(C_RED_MS - 1);
    localparam logic [MW-1:0] WALK_LAST   = MW'(C_WALK_MS - 1);

    typedef enum logic [2:0] {
        S_RED, S_GREEN, S_YELLOW, S_WALK, S_CLEAR
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [MW-1:0]   ms_q, ms_d;
    logic            min_q, min_d;
    logic            req_q, req_d;
    logic [1:0]      light_q, light_d;

    logic            tick;
    logic            done;
    logic [MW-1:0]   last_ms;

    // Next state, phase timing, request latch and output code
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        last_ms = RED_LAST;
        case (state_q)
            S_GREEN:  last_ms = GREEN_LAST;
            S_YELLOW: last_ms = YELLOW_LAST;
            S_WALK:   last_ms = WALK_LAST;
            default:  last_ms = RED_LAST;
        endcase
        // done is true on the edge that ends the phase (D*K edges after entry)
        done = tick && (ms_q == last_ms);

        state_d = state_q;
        case (state_q)
            S_RED:    if (done) state_d = req_q ? S_WALK : S_GREEN;
            S_GREEN:  if ((min_q || done) && req_q) state_d = S_YELLOW;
            S_YELLOW: if (done) state_d = S_RED;
            S_WALK:   if (done) state_d = S_CLEAR;
            S_CLEAR:  if (done) state_d = S_GREEN;
            default:  state_d = S_RED;
        endcase

        presc_d = presc_q;
        ms_d    = ms_q;
        min_d   = min_q;
        if (state_d != state_q) begin
            presc_d = '0;
            ms_d    = '0;
            min_d   = 1'b0;
        end else if (!(state_q == S_GREEN && min_q)) begin
            // Held green with min time elapsed: counters freeze (saturate)
            presc_d = tick ? '0 : presc_q + 1'b1;
            ms_d    = tick ? ms_q + 1'b1 : ms_q;
            if (state_q == S_GREEN && done) min_d = 1'b1;
        end

        // Clearing on walk entry wins over a simultaneous press; presses
        // while walking are dropped.
        req_d = (state_d == S_WALK) ? 1'b0 : (req_q | (|inPedestrian));

        case (state_d)
            S_GREEN:  light_d = 2'b01;
            S_YELLOW: light_d = 2'b10;
            S_WALK:   light_d = 2'b11;
            default:  light_d = 2'b00;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RED;
            presc_q <= '0;
            ms_q    <= '0;
            min_q   <= 1'b0;
            req_q   <= 1'b0;
            light_q <= 2'b00;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            min_q   <= min_d;
            req_q   <= req_d;
            light_q <= light_d;
        end
    end

    assign outLight      = light_q;
    assign outReqPending = req_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with K=2: green 10, yellow 6,
// red/clear 4, walk 8 cycles.
module tb_light_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] inPedestrian;
    logic [1:0] outLight;
    logic       outReqPending;

    int n_cmp  = 0;
    int n_fail = 0;

    light_sequencer #(
        .C_CLK_FRQ  (2000),
        .C_GREEN_MS (5),
        .C_YELLOW_MS(3),
        .C_RED_MS   (2),
        .C_WALK_MS  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inPedestrian (inPedestrian),
        .outLight     (outLight),
        .outReqPending(outReqPending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] ped;
        logic [1:0] light;
        logic       req;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    // Append n identical cycles: inputs for the edge, expected outputs after it
    task automatic add(input logic r, input logic [1:0] p, input logic [1:0] l,
                       input logic q, input int n, input string tag);
        vec_t v;
        v.rst = r; v.ped = p; v.light = l; v.req = q; v.tag = tag;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic [1:0] p);
        rst = r;
        inPedestrian = p;
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int lat;
        int cnt;
        rst = 1'b1;
        inPedestrian = 2'b00;

        // 1: reset, power-up red, then green held with no request
        add(1, 2'b00, 2'b00, 0, 2,   "reset");
        add(0, 2'b00, 2'b00, 0, 3,   "powerup_red");
        add(0, 2'b00, 2'b01, 0, 110, "green_hold");
        // 3: press in held green -> req after N, yellow after N+1
        add(0, 2'b10, 2'b01, 1, 1,   "held_press");
        add(0, 2'b00, 2'b10, 1, 6,   "yellow_a");
        add(0, 2'b00, 2'b00, 1, 4,   "red_a");
        add(0, 2'b00, 2'b11, 0, 8,   "walk_a");
        add(0, 2'b00, 2'b00, 0, 4,   "clear_a");
        // 2: pulse 3 cycles into green, served at min-green expiry
        add(0, 2'b00, 2'b01, 0, 3,   "green_b_pre");
        add(0, 2'b01, 2'b01, 1, 1,   "green_b_press");
        add(0, 2'b00, 2'b01, 1, 6,   "green_b_post");
        add(0, 2'b00, 2'b10, 1, 6,   "yellow_b");
        add(0, 2'b00, 2'b00, 1, 4,   "red_b");
        add(0, 2'b00, 2'b11, 0, 8,   "walk_b");
        add(0, 2'b00, 2'b00, 0, 4,   "clear_b");
        add(0, 2'b00, 2'b01, 0, 20,  "green_b_hold");
        // 4: press during walk ignored, press during clear latched
        add(0, 2'b01, 2'b01, 1, 1,   "press_c");
        add(0, 2'b00, 2'b10, 1, 6,   "yellow_c");
        add(0, 2'b00, 2'b00, 1, 4,   "red_c");
        add(0, 2'b00, 2'b11, 0, 2,   "walk_c");
        add(0, 2'b11, 2'b11, 0, 2,   "walk_c_press");
        add(0, 2'b00, 2'b11, 0, 4,   "walk_c_post");
        add(0, 2'b00, 2'b00, 0, 1,   "clear_c");
        add(0, 2'b01, 2'b00, 1, 1,   "clear_c_press");
        add(0, 2'b00, 2'b00, 1, 2,   "clear_c_post");
        add(0, 2'b00, 2'b01, 1, 10,  "green_c");
        // 5: reset mid-yellow with request pending -> red then green, no walk
        add(0, 2'b00, 2'b10, 1, 3,   "yellow_d");
        add(1, 2'b00, 2'b00, 0, 1,   "reset_mid_yellow");
        add(0, 2'b00, 2'b00, 0, 3,   "red_d");
        add(0, 2'b00, 2'b01, 0, 20,  "green_d");
        // 6: buttons held continuously -> repeating full cycle
        add(0, 2'b11, 2'b01, 1, 1,   "hold_press");
        for (int k = 0; k < 2; k++) begin
            add(0, 2'b11, 2'b10, 1, 6,  "hold_yellow");
            add(0, 2'b11, 2'b00, 1, 4,  "hold_red");
            add(0, 2'b11, 2'b11, 0, 8,  "hold_walk");
            add(0, 2'b11, 2'b00, 1, 4,  "hold_clear");
            add(0, 2'b11, 2'b01, 1, 10, "hold_green");
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ped);
            n_cmp++;
            if (outLight !== vecs[i].light) begin
                n_fail++;
                $display("FAIL %s light row %0d: got %b expected %b",
                         vecs[i].tag, i, outLight, vecs[i].light);
            end
            n_cmp++;
            if (outReqPending !== vecs[i].req) begin
                n_fail++;
                $display("FAIL %s req row %0d: got %b expected %b",
                         vecs[i].tag, i, outReqPending, vecs[i].req);
            end
        end

        // Power-up red length, measured with a bounded wait
        step(1, 2'b00);
        check_int("reset_light", int'(outLight), 0);
        cnt = 0;
        while (outLight != 2'b01 && cnt < 20) begin
            step(0, 2'b00);
            if (outLight != 2'b01) cnt++;
        end
        check_int("powerup_red_cycles", cnt + 1, 4);

        // Press-to-yellow latency in held green, bounded
        repeat (15) step(0, 2'b00);
        step(0, 2'b01);
        check_int("latency_req", int'(outReqPending), 1);
        check_int("latency_light_n", int'(outLight), 1);
        lat = 0;
        do begin
            step(0, 2'b00);
            lat++;
        end while (outLight != 2'b10 && lat < 20);
        check_int("press_to_yellow_latency", lat, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/light_sequencer.md
Name: light_sequencer

Overview:
- Traffic-light state machine that generates the 2-bit light-selection code consumed by the LED colour driver.
- Latches pedestrian requests, times each phase from a millisecond prescaler, and steps vehicle-green -> yellow -> red -> pedestrian walk -> red clearance -> green.
- Sits between the debounced button inputs and the LED driver.

Parameters:
- C_CLK_FRQ, 100000000: clock frequency [Hz]. Must be a multiple of 1000. K = C_CLK_FRQ/1000 cycles per ms.
- C_GREEN_MS, 5000: minimum vehicle-green time [ms], >=1.
- C_YELLOW_MS, 2000: yellow time [ms], >=1.
- C_RED_MS, 1000: all-red time, used both at power-up and as clearance [ms], >=1.
- C_WALK_MS, 4000: pedestrian walk time [ms], >=1.

Ports:
- clk  input  1  master clock
- rst  input  1  synchronous reset, active-high
- inPedestrian  input  2  debounced pedestrian buttons, level, one per crossing side
- outLight  output  2  light selection: 00 red, 01 green, 10 yellow, 11 white (walk)
- outReqPending  output  1  pedestrian request latched, not yet served (button lamp)

Behaviour:
- States and codes: S_RED(00), S_GREEN(01), S_YELLOW(10), S_WALK(11), S_CLEAR(00).
- outLight is registered and equals the code of the current state. It changes on the same edge as the state register.
- Reset (any state, any cycle): on the next edge, state = S_RED, outLight = 00, outReqPending = 0, prescaler = 0, ms timer = 0.
- Timing:
  - Prescaler counts 0..K-1. The ms counter increments on prescaler wrap.
  - Both counters clear on every state entry.
  - A state with duration D ms entered at edge E is left at edge E + D*K. Its code is visible for exactly D*K cycles.
- Transitions:
  - S_RED: after C_RED_MS -> S_WALK if outReqPending = 1, else S_GREEN.
  - S_GREEN: a sticky min-elapsed flag sets after C_GREEN_MS. While the flag is set, go to S_YELLOW on the first edge where outReqPending = 1. With no request, stay green indefinitely. The timer saturates and does not wrap.
  - S_YELLOW: after C_YELLOW_MS -> S_RED.
  - S_WALK: after C_WALK_MS -> S_CLEAR.
  - S_CLEAR: after C_RED_MS -> S_GREEN, always. It never returns to walk directly.
- Request latch:
  - Sets on any edge where |inPedestrian = 1, in every state except S_WALK.
  - Presses during S_WALK are ignored.
  - Clears on the edge that enters S_WALK. If a set and the clear occur on the same edge, clear wins.
- Press-to-yellow latency in held green: press sampled at edge N -> outReqPending = 1 after N -> outLight = 10 after N+1.
- A request pending before min-green expiry is served exactly at min-green expiry.
- Counter widths are derived with $clog2 from K and the largest duration. No overflow is permitted for the default parameters.

Test Plan:
Bench parameters: C_CLK_FRQ=2000 (K=2), GREEN=5, YELLOW=3, RED=2, WALK=4, giving 10/6/4/8 cycles.
1. Release rst, inPedestrian = 00 -> outLight = 00 for 4 cycles, then 01 held for 100+ cycles; outReqPending = 0 throughout.
2. Pulse inPedestrian = 01 for 1 cycle, 3 cycles into green:
   - outReqPending = 1 from the next cycle; green lasts 10 cycles total.
   - Then 10 for 6 cycles, 00 for 4, 11 for 8 (outReqPending drops on walk entry), 00 for 4, then 01 held.
3. After 50 cycles of held green, pulse inPedestrian = 10 at edge N -> outReqPending = 1 after N, outLight = 10 after N+1.
4. Press during S_WALK -> outReqPending stays 0 and green holds afterwards. Press during S_CLEAR -> latched, then yellow exactly 10 cycles after green entry.
5. Assert rst for 1 cycle mid-S_YELLOW with a request pending -> next edge outLight = 00, outReqPending = 0; after 4 cycles outLight = 01 (no walk).
6. Hold inPedestrian = 11 continuously -> repeating cycle of 10 x 01, 6 x 10, 4 x 00, 8 x 11, 4 x 00. outReqPending = 0 only during walk.
